ysyx_22041752_dmem_responder: RTL and testbench
===============================================

Name: ysyx_22041752_dmem_responder

Overview:
- Responder (slave) end of the data-SRAM request interface driven by the execute stage.
- Accepts one request per cycle with no backpressure.
- Aligns size-coded byte strobes and unshifted write data to the 8-byte word, performs writes, and returns read words after a fixed, parameterised latency.
- Flags out-of-range and boundary-crossing accesses; used as the simulation data memory behind the MEM stage.

Parameters:
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0.
- DEPTH_WORDS, 4096, number of 64-bit words; power of two.
- RD_LAT, 1, read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- data_sram_en  in  1  request valid this cycle
- data_sram_wen  in  8  size-coded strobe, unshifted: 00 = read, 01 = byte, 03 = half, 0F = word, FF = dword
- data_sram_addr  in  64  byte address
- data_sram_wdata  in  64  store data, LSB-justified (unshifted)
- data_sram_rdata  out  64  aligned 64-bit word containing the addressed bytes
- data_sram_rvalid  out  1  rdata valid; pulses exactly RD_LAT cycles after an accepted read
- data_sram_err  out  1  pulses RD_LAT cycles after an illegal request (read or write)

Behaviour:
- Reset values: rdata = 0, rvalid = 0, err = 0. The latency pipeline is flushed, so in-flight reads are dropped. The memory array is not cleared.
- Request accepted every cycle en = 1. No ready signal. Back-to-back requests are legal.
- Decode:
  - off = addr[2:0]
  - idx = (addr − BASE_ADDR) >> 3
  - size = popcount(wen): 0, 1, 2, 4 or 8
- Illegal request, any of:
  - addr < BASE_ADDR
  - addr ≥ BASE_ADDR + 8·DEPTH_WORDS
  - wen not in {00, 01, 03, 0F, FF}
  - off + max(size, 1) > 8 (crosses the 8-byte boundary)
- Illegal request handling: no array write; err pulses at request cycle + RD_LAT. For an illegal read, rvalid also pulses with rdata = 0.
- Write (en = 1, legal, wen ≠ 00):
  - Byte mask = wen << off; data = wdata << (8·off).
  - Only masked bytes are updated, at the clock edge of the request cycle.
  - rvalid is not asserted for writes.
- Read (en = 1, legal, wen = 00):
  - The array word is sampled in the request cycle.
  - The full word appears on rdata with rvalid = 1 at request cycle + RD_LAT.
  - The MEM stage extracts bytes and extends them.
- Read-after-write:
  - A read in cycle N+1 of a word written in cycle N returns the new data.
  - A read and write in the same cycle cannot happen: one request per cycle.
- rdata holds its last value when rvalid = 0.
- Latency pipeline: a RD_LAT-deep shift register of {valid, err, data}. Each stage advances every cycle.
- en = 0: inserts a bubble. Requests already in flight continue.
- reset asserted mid-operation: all stages are cleared next edge. Responses issued before reset are never delivered.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- When defined, adds outputs rd_cnt[31:0], wr_cnt[31:0] and err_cnt[31:0]. Each counts accepted legal reads, legal writes and illegal requests respectively. Cleared by reset; each wraps at 2^32 with no saturation.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared header ysyx_22041752_mycpu.vh holds:
  - SRAM_WEN_WD, SRAM_ADDR_WD, SRAM_DATA_WD
  - Size-code constants: WEN_B = 8'h01, WEN_H = 8'h03, WEN_W = 8'h0F, WEN_D = 8'hFF
- One combinational sub-module, ysyx_22041752_dmem_align. Inputs: off, wen, wdata. Outputs: shifted byte mask, shifted data, legal_size, cross_flag.
- The array, range check and latency pipeline stay in the top module.

Test Plan:
- Reset, then idle for 5 cycles → rvalid = 0, err = 0, rdata = 0.
- RD_LAT = 1. Write FF @0x80000000 with data 0x1122334455667788. Next cycle, read @0x80000000 → one cycle later rdata = 0x1122334455667788, rvalid = 1 for exactly 1 cycle.
- Byte write 01 @0x80000003 with data 0xAB, then read @0x80000000 → rdata = 0x11223344AB667788.
- Half write 03 @0x80000007 (crosses the boundary) → err pulses once, no write occurs, and a subsequent read still returns the prior word.
- RD_LAT = 3. Back-to-back reads of words 0, 1, 2 in consecutive cycles → three consecutive rvalid pulses starting at cycle +3, data in order. Assert reset during the second cycle → no rvalid is delivered after reset.
- Read @0x7FFFFFF8 → err = 1, rvalid = 1, rdata = 0. With DMEM_PERF_CNT_EN defined, err_cnt increments to 1 and rd_cnt is unchanged.

Source files
------------

// File: rtl/ysyx_22041752_dmem_responder_pkg.sv
// Shared SRAM interface widths and size-code constants for the data-memory responder.
package ysyx_22041752_dmem_responder_pkg;

  localparam int SRAM_WEN_WD  = 8;
  localparam int SRAM_ADDR_WD = 64;
  localparam int SRAM_DATA_WD = 64;

  localparam logic [SRAM_WEN_WD-1:0] WEN_B = 8'h01;
  localparam logic [SRAM_WEN_WD-1:0] WEN_H = 8'h03;
  localparam logic [SRAM_WEN_WD-1:0] WEN_W = 8'h0F;
  localparam logic [SRAM_WEN_WD-1:0] WEN_D = 8'hFF;

  // Access size in bytes for a size code; 0 for a read or an unknown code.
  function automatic logic [3:0] wen_size(input logic [SRAM_WEN_WD-1:0] wen);
    case (wen)
      WEN_B:   return 4'd1;
      WEN_H:   return 4'd2;
      WEN_W:   return 4'd4;
      WEN_D:   return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic wen_legal(input logic [SRAM_WEN_WD-1:0] wen);
    return (wen == '0) || (wen == WEN_B) || (wen == WEN_H) || (wen == WEN_W) || (wen == WEN_D);
  endfunction

endpackage

// File: rtl/ysyx_22041752_dmem_align.sv
// Combinational alignment of a size-coded strobe and LSB-justified store data to the 8-byte word.
module ysyx_22041752_dmem_align
  import ysyx_22041752_dmem_responder_pkg::*;
(
  input  logic [2:0]              off,
  input  logic [SRAM_WEN_WD-1:0]  wen,
  input  logic [SRAM_DATA_WD-1:0] wdata,
  output logic [SRAM_WEN_WD-1:0]  byte_mask,
  output logic [SRAM_DATA_WD-1:0] wdata_sh,
  output logic                    legal_size,
  output logic                    cross_flag
);

  logic [3:0] span;

  always_comb begin
    legal_size = wen_legal(wen);
    // A read still touches one byte, so it can cross only if the offset is out of a word.
    span       = (wen_size(wen) == 4'd0) ? 4'd1 : wen_size(wen);
    cross_flag = ({1'b0, off} + span) > 4'd8;
    byte_mask  = wen << off;
    wdata_sh   = wdata << {off, 3'b000};
  end

endmodule

// File: rtl/ysyx_22041752_dmem_responder.sv
// Data-SRAM responder: byte-masked writes, fixed-latency reads, illegal-access flagging.
// Optional performance counters are enabled by defining DMEM_PERF_CNT_EN.
module ysyx_22041752_dmem_responder
  import ysyx_22041752_dmem_responder_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LAT      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    data_sram_en,
  input  logic [SRAM_WEN_WD-1:0]  data_sram_wen,
  input  logic [SRAM_ADDR_WD-1:0] data_sram_addr,
  input  logic [SRAM_DATA_WD-1:0] data_sram_wdata,
  output logic [SRAM_DATA_WD-1:0] data_sram_rdata,
  output logic                    data_sram_rvalid,
  output logic                    data_sram_err
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]             rd_cnt,
  output logic [31:0]             wr_cnt,
  output logic [31:0]             err_cnt
`endif
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN_BYTES = 64'(DEPTH_WORDS) << 3;

  logic [SRAM_DATA_WD-1:0] mem [DEPTH_WORDS];

  logic [63:0]             rel;
  logic [IDX_W-1:0]        idx;
  logic                    in_range, illegal, is_read, do_write;
  logic [SRAM_WEN_WD-1:0]  byte_mask;
  logic [SRAM_DATA_WD-1:0] wdata_sh;
  logic                    legal_size, cross_flag;

  ysyx_22041752_dmem_align u_align (
    .off        (data_sram_addr[2:0]),
    .wen        (data_sram_wen),
    .wdata      (data_sram_wdata),
    .byte_mask  (byte_mask),
    .wdata_sh   (wdata_sh),
    .legal_size (legal_size),
    .cross_flag (cross_flag)
  );

  always_comb begin
    rel      = data_sram_addr - BASE_ADDR;
    in_range = (data_sram_addr >= BASE_ADDR) && (rel < SPAN_BYTES);
    idx      = rel[IDX_W+2:3];
    illegal  = !in_range || !legal_size || cross_flag;
    is_read  = (data_sram_wen == '0);
    do_write = data_sram_en && !illegal && !is_read;
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_mask[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // Stage inputs: index 0 is fed by the request, index k by stage k-1.
  logic [RD_LAT-1:0]       vld_p, err_p, vld_nxt, err_nxt;
  logic [SRAM_DATA_WD-1:0] data_p [RD_LAT];
  logic [SRAM_DATA_WD-1:0] data_nxt [RD_LAT];

  always_comb begin
    vld_nxt[0]  = data_sram_en && is_read;
    err_nxt[0]  = data_sram_en && illegal;
    data_nxt[0] = illegal ? '0 : mem[idx];
    for (int k = 1; k < RD_LAT; k++) begin
      vld_nxt[k]  = vld_p[k-1];
      err_nxt[k]  = err_p[k-1];
      data_nxt[k] = data_p[k-1];
    end
  end

  // Latency pipeline; the last data stage only loads on a valid response so rdata holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
      err_p <= '0;
    end else begin
      vld_p <= vld_nxt;
      err_p <= err_nxt;
    end
    for (int k = 0; k < RD_LAT - 1; k++) data_p[k] <= data_nxt[k];
    if (reset)                      data_p[RD_LAT-1] <= '0;
    else if (vld_nxt[RD_LAT-1])     data_p[RD_LAT-1] <= data_nxt[RD_LAT-1];
  end

  assign data_sram_rvalid = vld_p[RD_LAT-1];
  assign data_sram_err    = err_p[RD_LAT-1];
  assign data_sram_rdata  = data_p[RD_LAT-1];

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else if (data_sram_en) begin
      if (illegal)      err_cnt <= err_cnt + 32'd1;
      else if (is_read) rd_cnt  <= rd_cnt + 32'd1;
      else              wr_cnt  <= wr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22041752_dmem_responder.sv
// Scoreboard bench: two responders (RD_LAT 1 and 3) share stimulus; a memory model predicts responses.
module tb_ysyx_22041752_dmem_responder;

  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          DEPTH = 4096;

  logic        clk, reset, en;
  logic [7:0]  wen;
  logic [63:0] addr, wdata;
  logic [63:0] rdata1, rdata3;
  logic        rvalid1, rvalid3, err1, err3;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rd_cnt1, wr_cnt1, err_cnt1, rd_cnt3, wr_cnt3, err_cnt3;
`endif

  ysyx_22041752_dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata1),
    .data_sram_rvalid(rvalid1), .data_sram_err(err1)
`ifdef DMEM_PERF_CNT_EN
    , .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1), .err_cnt(err_cnt1)
`endif
  );

  ysyx_22041752_dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata3),
    .data_sram_rvalid(rvalid3), .data_sram_err(err3)
`ifdef DMEM_PERF_CNT_EN
    , .rd_cnt(rd_cnt3), .wr_cnt(wr_cnt3), .err_cnt(err_cnt3)
`endif
  );

  typedef struct {
    int          due;
    logic        vld;
    logic        err;
    logic [63:0] data;
  } resp_t;

  resp_t       q1[$];
  resp_t       q3[$];
  logic [63:0] mem_m [logic [63:0]];
  logic [63:0] last1, last3;
  int          checks, errors, cyc, rd_m, wr_m, err_m;
  bit          mon_on;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal_req(input logic [7:0] w, input logic [63:0] a);
    int sz;
    sz = $countones(w);
    if (a < BASE || a >= BASE + 64'(8 * DEPTH)) return 0;
    if (!(w inside {8'h00, 8'h01, 8'h03, 8'h0F, 8'hFF})) return 0;
    return (int'(a[2:0]) + ((sz == 0) ? 1 : sz)) <= 8;
  endfunction

  task automatic mon_port(input int lat, input logic rv, input logic er, input logic [63:0] rd);
    resp_t       e;
    bit          have;
    logic [63:0] last;
    e = '{due: 0, vld: 1'b0, err: 1'b0, data: 64'h0};
    if (lat == 1) begin
      have = q1.size() > 0;
      if (have) e = q1[0];
      last = last1;
    end else begin
      have = q3.size() > 0;
      if (have) e = q3[0];
      last = last3;
    end
    if (rv || er) begin
      checks++;
      if (!have || e.due != cyc) begin
        errors++;
        $display("FAIL resp_timing lat%0d: got rvalid=%0b err=%0b at cycle %0d, required due cycle %0d",
                 lat, rv, er, cyc, have ? e.due : -1);
        if (have && e.due < cyc) begin
          if (lat == 1) void'(q1.pop_front()); else void'(q3.pop_front());
        end
      end else begin
        if (lat == 1) void'(q1.pop_front()); else void'(q3.pop_front());
        chk($sformatf("rvalid_lat%0d", lat), 64'(rv), 64'(e.vld));
        chk($sformatf("err_lat%0d", lat), 64'(er), 64'(e.err));
        if (e.vld) begin
          chk($sformatf("rdata_lat%0d", lat), rd, e.data);
          last = e.data;
        end
      end
    end else begin
      if (have && e.due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_resp lat%0d: got no response at cycle %0d, required vld=%0b err=%0b due %0d",
                 lat, cyc, e.vld, e.err, e.due);
        if (lat == 1) void'(q1.pop_front()); else void'(q3.pop_front());
        if (e.vld) last = e.data;
      end
      chk($sformatf("rdata_hold_lat%0d", lat), rd, last);
    end
    if (lat == 1) last1 = last; else last3 = last;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon_port(1, rvalid1, err1, rdata1);
      mon_port(3, rvalid3, err3, rdata3);
    end
  end

  task automatic issue(input logic [7:0] w, input logic [63:0] a, input logic [63:0] d);
    resp_t       e;
    logic [63:0] wa, cur;
    int          off, sz;
    en = 1'b1; wen = w; addr = a; wdata = d;
    off = int'(a[2:0]);
    sz  = $countones(w);
    wa  = a & ~64'h7;
    e   = '{due: 0, vld: 1'b0, err: 1'b0, data: 64'h0};
    if (!legal_req(w, a)) begin
      err_m++;
      e.err = 1'b1;
      e.vld = (w == 8'h00);
    end else if (w == 8'h00) begin
      rd_m++;
      e.vld  = 1'b1;
      e.data = mem_m.exists(wa) ? mem_m[wa] : 64'h0;
    end else begin
      wr_m++;
      cur = mem_m.exists(wa) ? mem_m[wa] : 64'h0;
      for (int i = 0; i < sz; i++) cur[8*(off+i) +: 8] = d[8*i +: 8];
      mem_m[wa] = cur;
    end
    if (e.vld || e.err) begin
      e.due = cyc + 1; q1.push_back(e);
      e.due = cyc + 3; q3.push_back(e);
    end
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Responses due at or after the reset edge are flushed by the DUT.
  task automatic do_reset(input int n);
    en = 1'b0;
    reset = 1'b1;
    while (q1.size() > 0 && q1[q1.size()-1].due > cyc) void'(q1.pop_back());
    while (q3.size() > 0 && q3[q3.size()-1].due > cyc) void'(q3.pop_back());
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    last1 = 64'h0; last3 = 64'h0;
    rd_m = 0; wr_m = 0; err_m = 0;
  endtask

  function automatic logic [63:0] rand_addr();
    int sel, w;
    logic [63:0] off;
    sel = $urandom_range(0, 9);
    off = 64'($urandom_range(0, 7));
    if (sel == 0) return BASE - 64'h8 + off;
    if (sel == 1) return BASE + 64'(8 * DEPTH) + off;
    w = $urandom_range(0, 17);
    if (w >= 16) w = DEPTH - 18 + w;
    return BASE + 64'(8 * w) + off;
  endfunction

  function automatic logic [7:0] rand_wen();
    case ($urandom_range(0, 9))
      0, 1, 2: return 8'h00;
      3:       return 8'h01;
      4:       return 8'h03;
      5:       return 8'h0F;
      6:       return 8'hFF;
      7:       return 8'($urandom);
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    checks = 0; errors = 0; cyc = 0; mon_on = 1'b0;
    rd_m = 0; wr_m = 0; err_m = 0;
    en = 1'b0; wen = 8'h00; addr = BASE; wdata = 64'h0;
    last1 = 64'h0; last3 = 64'h0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_on = 1'b1;
    idle(5);

    issue(8'hFF, BASE, 64'h1122_3344_5566_7788);
    issue(8'h00, BASE, 64'h0);
    idle(4);
    issue(8'h01, BASE + 64'h3, 64'h0000_0000_0000_00AB);
    issue(8'h00, BASE, 64'h0);
    idle(4);
    issue(8'h03, BASE + 64'h7, 64'h0000_0000_0000_BEEF);
    issue(8'h00, BASE, 64'h0);
    idle(4);

    for (int w = 1; w < 16; w++) issue(8'hFF, BASE + 64'(8 * w), {$urandom, $urandom});
    issue(8'hFF, BASE + 64'(8 * (DEPTH - 2)), {$urandom, $urandom});
    issue(8'hFF, BASE + 64'(8 * (DEPTH - 1)), {$urandom, $urandom});
    idle(2);

    issue(8'h00, BASE, 64'h0);
    issue(8'h00, BASE + 64'h8, 64'h0);
    issue(8'h00, BASE + 64'h10, 64'h0);
    idle(5);

    issue(8'h00, BASE, 64'h0);
    do_reset(1);
    idle(6);

    issue(8'h00, 64'h0000_0000_7FFF_FFF8, 64'h0);
    idle(5);
`ifdef DMEM_PERF_CNT_EN
    chk("err_cnt_lat3", 64'(err_cnt3), 64'(err_m));
    chk("rd_cnt_lat3", 64'(rd_cnt3), 64'(rd_m));
`endif

    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset(1);
      issue(rand_wen(), rand_addr(), {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(6);

    chk("q_lat1_drained", 64'(q1.size()), 64'h0);
    chk("q_lat3_drained", 64'(q3.size()), 64'h0);
`ifdef DMEM_PERF_CNT_EN
    chk("rd_cnt_lat1", 64'(rd_cnt1), 64'(rd_m));
    chk("wr_cnt_lat1", 64'(wr_cnt1), 64'(wr_m));
    chk("err_cnt_lat1", 64'(err_cnt1), 64'(err_m));
    chk("wr_cnt_lat3_end", 64'(wr_cnt3), 64'(wr_m));
`endif
    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
